// File: rtl/complex_multiply_if.sv
// complex_multiply_if
// -------------------
// Purpose: groups the two operand streams and the product stream of the
// complex multiplier into one bundle.
//
// Signals (WIDTH = bits per real/imag component, data packed {imag, real}):
//   s_a_valid / s_a_ready / s_a_data  operand A stream
//   s_b_valid / s_b_ready / s_b_data  operand B stream (normally conj(b))
//   m_valid   / m_ready   / m_data    product stream
//
// Modports:
//   slave  - the multiplier itself (consumes A/B, produces the product)
//   master - whoever drives A/B and accepts the product
interface complex_multiply_if #(
  parameter int WIDTH = 16
);

  logic               s_a_valid;
  logic               s_a_ready;
  logic [2*WIDTH-1:0] s_a_data;
  logic               s_b_valid;
  logic               s_b_ready;
  logic [2*WIDTH-1:0] s_b_data;
  logic               m_valid;
  logic               m_ready;
  logic [2*WIDTH-1:0] m_data;

  modport slave (
    input  s_a_valid, s_a_data, s_b_valid, s_b_data, m_ready,
    output s_a_ready, s_b_ready, m_valid, m_data
  );

  modport master (
    output s_a_valid, s_a_data, s_b_valid, s_b_data, m_ready,
    input  s_a_ready, s_b_ready, m_valid, m_data
  );

endinterface

// File: rtl/complex_multiply.sv
// complex_multiply
// ----------------
// Purpose: three-stage pipelined complex multiplier. Joins operand streams A
// and B, forms a*b at full precision, arithmetically shifts right by SHIFT
// and saturates each component back to WIDTH bits.
//
// Parameters:
//   WIDTH  bits per signed real/imag component
//   SHIFT  right shift of the full-precision result (1..2*WIDTH)
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      complex_multiply_if.slave (A, B and product streams)
//
// Optional feature: define COMPLEX_MULTIPLY_ROUND_EN to add 2^(SHIFT-1)
// before the shift (round-half-up). Undefined gives plain truncation.
// Latency is the same either way.
module complex_multiply #(
  parameter int WIDTH = 16,
  parameter int SHIFT = WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  complex_multiply_if.slave     bus
);

  localparam int PW = 2 * WIDTH;
  // Sum of two products needs one extra bit, the rounding add one more.
  localparam int SW = 2 * WIDTH + 2;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic                  w_ce;
  logic                  w_accept;
  logic                  r_s1Valid;
  logic                  r_s2Valid;
  logic                  r_mValid;
  logic signed [WIDTH-1:0] r_ar;
  logic signed [WIDTH-1:0] r_ai;
  logic signed [WIDTH-1:0] r_br;
  logic signed [WIDTH-1:0] r_bi;
  logic signed [PW-1:0]  r_pArBr;
  logic signed [PW-1:0]  r_pAiBi;
  logic signed [PW-1:0]  r_pArBi;
  logic signed [PW-1:0]  r_pAiBr;
  logic signed [SW-1:0]  w_reSum;
  logic signed [SW-1:0]  w_imSum;
  logic signed [SW-1:0]  w_reRnd;
  logic signed [SW-1:0]  w_imRnd;
  logic [WIDTH-1:0]      w_reSat;
  logic [WIDTH-1:0]      w_imSat;
  logic [2*WIDTH-1:0]    r_mData;

  // Full-width signed product of two components; operands are sign-extended
  // first so the multiply is evaluated at the product width.
  function automatic logic signed [PW-1:0] mulExt(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = {{WIDTH{x[WIDTH-1]}}, x};
    ye = {{WIDTH{y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  function automatic logic signed [SW-1:0] sumExt(input logic signed [PW-1:0] p);
    return {{2{p[PW-1]}}, p};
  endfunction

  // Floor shift followed by clamping to the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] scaleSat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] sh;
    sh = v >>> SHIFT;
    if (sh > SAT_MAX)
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (sh < SAT_MIN)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return sh[WIDTH-1:0];
  endfunction

  // One enable freezes the whole pipeline while the product is stalled, so
  // bubbles are preserved and nothing is lost or duplicated.
  assign w_ce          = !r_mValid || bus.m_ready;
  assign bus.s_a_ready = w_ce && bus.s_b_valid;
  assign bus.s_b_ready = w_ce && bus.s_a_valid;
  assign w_accept      = w_ce && bus.s_a_valid && bus.s_b_valid;

  assign w_reSum = sumExt(r_pArBr) - sumExt(r_pAiBi);
  assign w_imSum = sumExt(r_pArBi) + sumExt(r_pAiBr);

`ifdef COMPLEX_MULTIPLY_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1) << (SHIFT - 1);
  assign w_reRnd = w_reSum + RND;
  assign w_imRnd = w_imSum + RND;
`else
  assign w_reRnd = w_reSum;
  assign w_imRnd = w_imSum;
`endif

  assign w_reSat = scaleSat(w_reRnd);
  assign w_imSat = scaleSat(w_imRnd);

  assign bus.m_valid = r_mValid;
  assign bus.m_data  = r_mData;

  // Stage valid bits: the only reset state. A reset drops every sample that
  // is in flight, including a pair offered during the reset cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
      r_mValid  <= 1'b0;
    end else if (w_ce) begin
      r_s1Valid <= w_accept;
      r_s2Valid <= r_s1Valid;
      r_mValid  <= r_s2Valid;
    end
  end

  // Data path registers, not reset; their content only matters when the
  // matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_ar    <= bus.s_a_data[WIDTH-1:0];
      r_ai    <= bus.s_a_data[2*WIDTH-1:WIDTH];
      r_br    <= bus.s_b_data[WIDTH-1:0];
      r_bi    <= bus.s_b_data[2*WIDTH-1:WIDTH];
      r_pArBr <= mulExt(r_ar, r_br);
      r_pAiBi <= mulExt(r_ai, r_bi);
      r_pArBi <= mulExt(r_ar, r_bi);
      r_pAiBr <= mulExt(r_ai, r_br);
      r_mData <= {w_imSat, w_reSat};
    end
  end

endmodule

// File: tb/tb_complex_multiply.sv
// tb_complex_multiply
// -------------------
// Purpose: self-checking bench for complex_multiply (WIDTH=16, SHIFT=15).
// A negedge monitor pushes the reference product of every accepted pair into
// a queue and pops/compares it whenever the DUT hands over a product.
// Directed sequences additionally check latency, saturation, rounding, the
// join handshake, stalls and reset. Honours COMPLEX_MULTIPLY_ROUND_EN.
module tb_complex_multiply;

  localparam int WIDTH = 16;
  localparam int SHIFT = 15;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  complex_multiply_if #(.WIDTH(WIDTH)) bus ();

  complex_multiply #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus.slave)
  );

  int          errorCount   = 0;
  int          checkCount   = 0;
  int          acceptCount  = 0;
  int          outCount     = 0;
  int          droppedCount = 0;
  logic [31:0] expQ[$];

  logic        obsAccept;
  logic        obsMValid;
  logic        obsAReady;
  logic        obsBReady;
  logic [31:0] obsMData;

  logic        curAV;
  logic        curBV;
  logic [31:0] curAD;
  logic [31:0] curBD;
  logic        lastAcc;
  int          pairs;
  int          cyc;
  int          idx;
  int          startAcc;
  int          startOut;
  logic [31:0] pa[5];
  logic [31:0] pb[5];
  logic [31:0] exp0;

  // Counts every comparison and reports any mismatch on one line.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)",
               tag, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [31:0] pack(input int re, input int im);
    return {im[15:0], re[15:0]};
  endfunction

  // Reference: exact integer math, optional round, floor shift, clamp.
  function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
    longint ar, ai, br, bi, re, im, hi, lo;
    ar = longint'(signed'(a[15:0]));
    ai = longint'(signed'(a[31:16]));
    br = longint'(signed'(b[15:0]));
    bi = longint'(signed'(b[31:16]));
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
`ifdef COMPLEX_MULTIPLY_ROUND_EN
    re = re + (longint'(1) <<< (SHIFT - 1));
    im = im + (longint'(1) <<< (SHIFT - 1));
`endif
    re = re >>> SHIFT;
    im = im >>> SHIFT;
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (WIDTH - 1));
    if (re > hi) re = hi; else if (re < lo) re = lo;
    if (im > hi) im = hi; else if (im < lo) im = lo;
    return {im[15:0], re[15:0]};
  endfunction

  function automatic logic [15:0] randComp();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drives one cycle of inputs (just after posedge), captures what the DUT
  // shows at the following negedge, then returns just after the next posedge.
  task automatic applyStimulus(input logic aV, input logic [31:0] aD,
                               input logic bV, input logic [31:0] bD,
                               input logic mR);
    bus.s_a_valid = aV;
    bus.s_a_data  = aD;
    bus.s_b_valid = bV;
    bus.s_b_data  = bD;
    bus.m_ready   = mR;
    @(negedge clk);
    obsAccept = bus.s_a_valid && bus.s_b_valid && bus.s_a_ready;
    obsMValid = bus.m_valid;
    obsMData  = bus.m_data;
    obsAReady = bus.s_a_ready;
    obsBReady = bus.s_b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  // One pair into an empty pipeline; product must show up on the third
  // cycle after the accept cycle and match a hand-derived constant.
  task automatic runSingle(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(1'b1, a, 1'b1, b, 1'b1);
    checkOutput({tag, "_accept"}, obsAccept, 1);
    drain(1);
    checkOutput({tag, "_lat1"}, obsMValid, 0);
    drain(1);
    checkOutput({tag, "_lat2"}, obsMValid, 0);
    drain(1);
    checkOutput({tag, "_valid"}, obsMValid, 1);
    checkOutput({tag, "_data"}, obsMData, expected);
  endtask

  // Scoreboard monitor: sampled at negedge, away from the active edge.
  always @(negedge clk) begin
    if (resetN !== 1'b1) begin
      droppedCount += expQ.size();
      expQ.delete();
    end else begin
      if (bus.s_a_valid && bus.s_b_valid && bus.s_a_ready) begin
        expQ.push_back(modelMul(bus.s_a_data, bus.s_b_data));
        acceptCount++;
      end
      if (bus.m_valid && bus.m_ready) begin
        outCount++;
        if (expQ.size() == 0)
          checkOutput("output_without_accept", outCount, acceptCount - droppedCount);
        else
          checkOutput("scoreboard", bus.m_data, expQ.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $display("Result: errors=%0d of %0d checks", errorCount + 1, checkCount + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetN = 1'b0;
    bus.s_a_valid = 1'b0;
    bus.s_b_valid = 1'b0;
    bus.s_a_data  = '0;
    bus.s_b_data  = '0;
    bus.m_ready   = 1'b1;
    @(posedge clk);
    #1;

    // Reset: readies follow their equations, the offered pair is dropped.
    applyStimulus(1'b1, pack(5, 5), 1'b1, pack(7, 7), 1'b1);
    checkOutput("reset_a_ready", obsAReady, 1);
    checkOutput("reset_b_ready", obsBReady, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    resetN = 1'b1;
    drain(1);
    checkOutput("reset_m_valid", obsMValid, 0);
    drain(3);
    checkOutput("reset_pair_dropped", obsMValid, 0);

    // Basic product, saturation and rounding.
    runSingle("basic", pack(16384, 0), pack(16384, 0), pack(8192, 0));
    drain(2);
    runSingle("sat_pos", pack(-32768, 0), pack(-32768, 0), pack(32767, 0));
    drain(2);
    runSingle("sat_none", pack(0, -32768), pack(0, -32768), pack(-32768, 0));
    drain(2);
`ifdef COMPLEX_MULTIPLY_ROUND_EN
    runSingle("round", pack(100, 200), pack(300, -400), pack(3, 1));
`else
    runSingle("trunc", pack(100, 200), pack(300, -400), pack(3, 0));
`endif
    drain(4);

    // Lone valid on A: never consumed, A side not ready.
    startAcc = acceptCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, pack(11, 22), 1'b0, 32'h0, 1'b1);
      checkOutput("lone_a_ready", obsAReady, 0);
    end
    checkOutput("lone_no_accept", acceptCount - startAcc, 0);
    drain(4);

    // Backpressure: 3 pairs fit, output frozen on the first product.
    for (int i = 0; i < 5; i++) begin
      pa[i] = pack(300 * (i + 1) - 1000, -100 * i + 77);
      pb[i] = pack(2000 + 13 * i, 50 * i - 900);
    end
    exp0 = modelMul(pa[0], pb[0]);
    idx = 0;
    startOut = outCount;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, pa[idx], 1'b1, pb[idx], 1'b0);
      if (obsAccept) idx++;
      if (c >= 4) begin
        checkOutput("stall_valid", obsMValid, 1);
        checkOutput("stall_data", obsMData, exp0);
        checkOutput("stall_a_ready", obsAReady, 0);
      end
    end
    checkOutput("stall_accepts", idx, 3);
    for (int c = 0; c < 20 && idx < 5; c++) begin
      applyStimulus(1'b1, pa[idx], 1'b1, pb[idx], 1'b1);
      if (obsAccept) idx++;
    end
    checkOutput("stall_all_accepted", idx, 5);
    drain(8);
    checkOutput("stall_outputs", outCount - startOut, 5);

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, pack(1234 + i, -555), 1'b1, pack(4321, 999 + i), 1'b1);
      checkOutput("inflight_accept", obsAccept, 1);
    end
    resetN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    resetN = 1'b1;
    drain(1);
    checkOutput("midreset_m_valid", obsMValid, 0);
    for (int i = 0; i < 4; i++) begin
      drain(1);
      checkOutput("midreset_no_output", obsMValid, 0);
    end
    runSingle("after_reset", pack(-16384, 8192), pack(16384, 0), pack(-8192, 4096));
    drain(4);

    // Random streaming with held data on unconsumed valids.
    curAV = 1'b0;
    curBV = 1'b0;
    curAD = '0;
    curBD = '0;
    lastAcc = 1'b0;
    pairs = 0;
    cyc = 0;
    while (pairs < 10000 && cyc < 60000) begin
      if (!curAV || lastAcc) begin
        curAV = ($urandom_range(3) != 0);
        curAD = {randComp(), randComp()};
      end
      if (!curBV || lastAcc) begin
        curBV = ($urandom_range(3) != 0);
        curBD = {randComp(), randComp()};
      end
      applyStimulus(curAV, curAD, curBV, curBD, $urandom_range(3) != 0);
      lastAcc = obsAccept;
      if (obsAccept) pairs++;
      cyc++;
    end
    checkOutput("stream_pairs", pairs, 10000);
    drain(10);

    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("out_count", outCount, acceptCount - droppedCount);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
